// File: rtl/neopixel_frame_sched.sv
// Frame scheduler for a WS2812 chain: arbitrated pixel writes into a frame buffer,
// per-pixel streaming to the bit serializer, then a latch gap before the next frame.
module neopixel_frame_sched #(
   parameter int NUM_LEDS     = 7,
   parameter int FRAME_PERIOD = 416667,
   parameter int LATCH_CYCLES = 1300
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_idx,
   input  logic [23:0] req0_rgb,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_idx,
   input  logic [23:0] req1_rgb,
   output logic        req1_ready,
   input  logic        frame_req,
   output logic        px_valid,
   input  logic        px_ready,
   output logic [23:0] px_data,
   output logic        px_last,
   input  logic        ser_busy,
   output logic        busy,
   output logic        frame_done,
   output logic        wr_drop
);

   localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int TW = $clog2(FRAME_PERIOD);
   localparam int CW = $clog2(LATCH_CYCLES + 1);
   localparam logic [7:0]    LAST_IDX = 8'(NUM_LEDS - 1);
   localparam logic [7:0]    NUM_IDX  = 8'(NUM_LEDS);
   localparam logic [TW-1:0] TICK_CNT = TW'(FRAME_PERIOD - 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

   state_t        state;
   logic [23:0]   buffer [NUM_LEDS];
   logic [7:0]    pix_idx;
   logic [CW-1:0] lat_cnt;
   logic [TW-1:0] timer;
   logic          dirty;
   logic          pending;
   logic          rr;

   logic          arb_on;
   logic          grant;
   logic          wr_ok;
   logic          tick;
   logic          start;
   logic [7:0]    wr_idx;
   logic [23:0]   wr_rgb;

   // rr = 0 gives requester 0 priority on a tie; writes only while not streaming
   assign arb_on     = rst_n && ((state == IDLE) || (state == LATCH));
   assign req0_ready = arb_on && req0_valid && (!req1_valid || !rr);
   assign req1_ready = arb_on && req1_valid && (!req0_valid || rr);
   assign grant      = req0_ready || req1_ready;
   assign wr_idx     = req1_ready ? req1_idx : req0_idx;
   assign wr_rgb     = req1_ready ? req1_rgb : req0_rgb;
   assign wr_ok      = grant && (wr_idx < NUM_IDX);
   assign wr_drop    = grant && !wr_ok;
   assign tick       = (timer == TICK_CNT);
   assign start      = (state == IDLE) && (frame_req || pending || (tick && dirty));

   always_ff @(posedge clk) begin
      if (wr_ok)
         buffer[wr_idx[AW-1:0]] <= wr_rgb;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pix_idx    <= '0;
         lat_cnt    <= '0;
         timer      <= '0;
         dirty      <= 1'b0;
         pending    <= 1'b0;
         rr         <= 1'b0;
         px_valid   <= 1'b0;
         px_data    <= '0;
         px_last    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         timer      <= tick ? '0 : timer + 1'b1;
         frame_done <= 1'b0;
         if (grant)
            rr <= req0_ready;
         if (wr_ok)
            dirty <= 1'b1;
         if (frame_req && (state != IDLE))
            pending <= 1'b1;
         case (state)
            IDLE: begin
               // a write granted in this same cycle belongs to the new frame
               if (start) begin
                  state   <= FETCH;
                  pix_idx <= '0;
                  dirty   <= 1'b0;
                  pending <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            FETCH: begin
               px_data  <= buffer[pix_idx[AW-1:0]];
               px_valid <= 1'b1;
               px_last  <= (pix_idx == LAST_IDX);
               state    <= SEND;
            end
            SEND: begin
               if (px_ready) begin
                  px_valid <= 1'b0;
                  px_last  <= 1'b0;
                  if (pix_idx == LAST_IDX) begin
                     state      <= LATCH;
                     lat_cnt    <= '0;
                     frame_done <= (LATCH_CYCLES == 1);
                  end else begin
                     pix_idx <= pix_idx + 1'b1;
                     state   <= FETCH;
                  end
               end
            end
            LATCH: begin
               // frame_done is raised one edge early so it coincides with the final count
               if (lat_cnt == LAT_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (ser_busy) begin
                  lat_cnt <= '0;
               end else begin
                  lat_cnt    <= lat_cnt + 1'b1;
                  frame_done <= ((lat_cnt + 1'b1) == LAT_LAST);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neopixel_frame_sched.sv
// Scoreboard bench for neopixel_frame_sched: expected pixels are queued when a frame
// is requested and compared at each serializer handshake.
module tb_neopixel_frame_sched;

   localparam int NL = 7;
   localparam int FP = 200;
   localparam int LC = 20;

   typedef struct packed {
      logic [23:0] data;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [7:0]  req0_idx, req1_idx;
   logic [23:0] req0_rgb, req1_rgb;
   logic        req0_ready, req1_ready;
   logic        frame_req;
   logic        px_valid, px_ready, px_last;
   logic [23:0] px_data;
   logic        ser_busy;
   logic        busy, frame_done, wr_drop;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   exp_t        sbq[$];
   logic [23:0] model_buf [NL];

   neopixel_frame_sched #(.NUM_LEDS(NL), .FRAME_PERIOD(FP), .LATCH_CYCLES(LC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_rgb(req0_rgb), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_rgb(req1_rgb), .req1_ready(req1_ready),
      .frame_req(frame_req), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
      .px_last(px_last), .ser_busy(ser_busy), .busy(busy), .frame_done(frame_done),
      .wr_drop(wr_drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      frame_req = 1'b0; ser_busy = 1'b0; px_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      sbq.delete();
   endtask

   task automatic push_frame();
      exp_t e;
      for (int i = 0; i < NL; i++) begin
         e.data = model_buf[i];
         e.last = (i == NL - 1);
         sbq.push_back(e);
      end
   endtask

   task automatic wr(input int who, input logic [7:0] idx, input logic [23:0] rgb, input logic drop);
      if (who == 0) begin
         req0_valid = 1'b1; req0_idx = idx; req0_rgb = rgb;
      end else begin
         req1_valid = 1'b1; req1_idx = idx; req1_rgb = rgb;
      end
      sample();
      $display("wr req%0d idx=%0d rgb=%h drop=%b", who, idx, rgb, wr_drop);
      check("wr_ready", (who == 0) ? req0_ready : req1_ready, 1);
      check("wr_drop", wr_drop, drop);
      if (!drop) model_buf[idx] = rgb;
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic kick(output int t);
      frame_req = 1'b1;
      t = cyc;
      step();
      frame_req = 1'b0;
   endtask

   // Runs until frame_done; returns the last-handshake and frame_done cycles.
   task automatic run_frame(input int busy_len, input bit toggle, output int t_last, output int t_done);
      t_last = -1;
      t_done = -1;
      for (int k = 0; k < 3000; k++) begin
         sample();
         if (px_valid && px_ready && px_last) t_last = cyc;
         if (frame_done) begin
            t_done = cyc;
            break;
         end
         step();
         ser_busy = (t_last >= 0) && (cyc <= t_last + busy_len);
         if (toggle) px_ready = ~px_ready;
      end
      if (t_done < 0) check("frame_timeout", 0, 1);
      step();
      px_ready = 1'b1;
      ser_busy = 1'b0;
   endtask

   // Scoreboard side: pop on every handshake, and check data holds while stalled
   initial begin
      logic        stall;
      logic [23:0] held;
      exp_t        e;
      int          n;
      stall = 1'b0; held = '0; n = 0;
      forever begin
         @(negedge clk);
         if (stall && px_valid) check("px_hold", px_data, held);
         if (px_valid && px_ready) begin
            $display("px %0d data=%h last=%b", n, px_data, px_last);
            n++;
            if (sbq.size() == 0) begin
               check("sb_underflow", 1, 0);
            end else begin
               e = sbq.pop_front();
               check("px_data", px_data, e.data);
               check("px_last", px_last, e.last);
            end
         end
         stall = px_valid && !px_ready;
         held = px_data;
      end
   end

   initial begin
      int t, tl, td, hs;
      logic seen, got;
      for (int i = 0; i < NL; i++) model_buf[i] = '0;
      req0_idx = '0; req1_idx = '0; req0_rgb = '0; req1_rgb = '0;
      rst_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      frame_req = 1'b0; ser_busy = 1'b0; px_ready = 1'b1;
      step(); step(); step();
      sample();
      check("rst_outs", {req0_ready, req1_ready, px_valid, px_last, busy, frame_done, wr_drop}, 0);
      check("rst_data", px_data, 0);
      step();
      rst_n = 1'b1;

      // idle with no requests: nothing may move
      seen = 1'b0;
      for (int k = 0; k < 2 * FP; k++) begin
         sample();
         seen |= |{req0_ready, req1_ready, px_valid, px_last, busy, frame_done, wr_drop, px_data};
         step();
      end
      check("idle_quiet", seen, 0);

      // single frame with exact start latency, streaming length and latch gap
      do_reset();
      for (int i = 0; i < NL; i++) wr(0, 8'(i), 24'h010203 + 24'(i), 1'b0);
      push_frame();
      frame_req = 1'b1;
      t = cyc;
      sample();
      check("busy_T", busy, 0);
      step();
      frame_req = 1'b0;
      sample();
      check("busy_T1", busy, 1);
      check("pxv_T1", px_valid, 0);
      step();
      sample();
      check("pxv_T2", px_valid, 1);
      step();
      run_frame(0, 1'b0, tl, td);
      check("stream_len", tl - t, 2 * NL);
      check("latch_gap", td - tl, LC);
      check("sb_drain1", sbq.size(), 0);

      // arbitration alternates from req0 after reset
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_idx = 8'(k); req1_idx = 8'(k);
         req0_rgb = 24'hA00000 + 24'(k); req1_rgb = 24'hB00000 + 24'(k);
         sample();
         check("arb_r0", req0_ready, (k % 2 == 0));
         check("arb_r1", req1_ready, (k % 2 == 1));
         model_buf[k] = (k % 2 == 0) ? req0_rgb : req1_rgb;
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      push_frame();
      kick(t);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_idx = 8'd7; req1_idx = 8'd7;
      seen = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         sample();
         seen |= req0_ready | req1_ready;
         if (px_valid && px_ready && px_last) begin
            got = 1'b1;
            break;
         end
         step();
      end
      check("send_last_seen", got, 1);
      check("send_ready", seen, 0);
      step();
      sample();
      check("latch_r0", req0_ready, 1);
      check("latch_r1", req1_ready, 0);
      check("latch_drop", wr_drop, 1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      run_frame(0, 1'b0, tl, td);
      check("sb_drain2", sbq.size(), 0);

      // backpressure and serializer busy stretching the latch gap
      do_reset();
      push_frame();
      kick(t);
      run_frame(100, 1'b1, tl, td);
      check("busy_latch", td - tl, 100 + LC);
      check("sb_drain3", sbq.size(), 0);

      // out-of-range write is dropped and must not arm a tick frame
      do_reset();
      wr(1, 8'd7, 24'hDEAD00, 1'b1);
      sample();
      check("drop_once", wr_drop, 0);
      step();
      seen = 1'b0;
      for (int k = 0; k < 2 * FP; k++) begin
         sample();
         seen |= busy;
         step();
      end
      check("no_tick_frame", seen, 0);

      // a real write makes the buffer dirty; the next tick starts a frame
      wr(0, 8'd2, 24'h123456, 1'b0);
      push_frame();
      got = 1'b0;
      for (int k = 0; k < FP + 10; k++) begin
         sample();
         if (busy) begin
            got = 1'b1;
            break;
         end
         step();
      end
      check("tick_frame", got, 1);
      step();
      run_frame(0, 1'b0, tl, td);
      check("sb_drain4", sbq.size(), 0);

      // frame_req during SEND is remembered and starts right after frame_done
      do_reset();
      push_frame();
      push_frame();
      kick(t);
      step();
      frame_req = 1'b1;
      sample();
      check("pend_in_send", px_valid, 1);
      step();
      frame_req = 1'b0;
      run_frame(0, 1'b0, tl, td);
      sample();
      check("pend_idle", busy, 0);
      step();
      sample();
      check("pend_start", busy, 1);
      step();
      run_frame(0, 1'b0, tl, td);
      check("sb_drain5", sbq.size(), 0);

      // reset while pixel 3 is stalled; the buffer must survive
      do_reset();
      push_frame();
      kick(t);
      hs = 0;
      for (int k = 0; k < 100; k++) begin
         sample();
         if (px_valid && px_ready) hs++;
         if (hs == 3) break;
         step();
      end
      check("hs3_reached", hs, 3);
      step();
      px_ready = 1'b0;
      step();
      sample();
      check("px3_valid", px_valid, 1);
      check("px3_data", px_data, model_buf[3]);
      step();
      rst_n = 1'b0;
      sample();
      step();
      sample();
      check("rst_pxv", px_valid, 0);
      check("rst_busy", busy, 0);
      check("sb_left", sbq.size(), NL - 3);
      step();
      sbq.delete();
      rst_n = 1'b1;
      px_ready = 1'b1;
      push_frame();
      kick(t);
      run_frame(0, 1'b0, tl, td);
      check("sb_drain6", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
